// File: rtl/lsu_subword.sv
// Byte/half/word load-store unit between the CPU MEM stage and a word-wide little-endian RAM.
// Define LSU_MISALIGN_ERR_EN to report misaligned accesses as errors instead of force-aligning them.
module lsu_subword #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_w_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic [3:0]        wait_cnt;
  logic              w_en_q;
  logic              valid_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       wword_q;
  logic [ADDR_W-3:0] maddr_q;

  logic              f3_illegal;
  logic              req_err;
  logic [1:0]        req_off;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;
  logic [31:0]       merge_word;
`ifdef LSU_MISALIGN_ERR_EN
  logic              misaligned;
`endif

  // Request decode; offsets below the access size are dropped so unaligned
  // accesses (when not flagged) behave as the aligned access containing them.
  always_comb begin
    f3_illegal = req_we ? (req_f3 > 3'd2)
                        : (req_f3 == 3'd3 || req_f3 == 3'd6 || req_f3 == 3'd7);
`ifdef LSU_MISALIGN_ERR_EN
    misaligned = (req_f3[1:0] == 2'd1 && req_addr[0]) ||
                 (req_f3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
    req_err    = f3_illegal || misaligned;
`else
    req_err    = f3_illegal;
`endif
    case (req_f3[1:0])
      2'd0:    req_off = req_addr[1:0];
      2'd1:    req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (f3_q[1:0])
      2'd0:    load_ext = {{24{lane_byte[7] & ~f3_q[2]}}, lane_byte};
      2'd1:    load_ext = {{16{lane_half[15] & ~f3_q[2]}}, lane_half};
      default: load_ext = mem_rdata;
    endcase

    merge_word = mem_rdata;
    if (f3_q[1:0] == 2'd0) begin
      case (off_q)
        2'd0:    merge_word[7:0]   = wdata_q[7:0];
        2'd1:    merge_word[15:8]  = wdata_q[7:0];
        2'd2:    merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merge_word[31:16] = wdata_q;
    end else begin
      merge_word[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      wdata_q  <= 16'd0;
      wait_cnt <= 4'd0;
      w_en_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      wword_q  <= 32'd0;
      maddr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_f3;
            off_q   <= req_off;
            wdata_q <= req_wdata[15:0];
            maddr_q <= req_addr[ADDR_W-1:2];
            if (req_err) begin
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state   <= RESP;
            end else if (req_we && req_f3 == 3'd2) begin
              wword_q <= req_wdata;
              w_en_q  <= 1'b1;
              state   <= WR;
            end else begin
              wait_cnt <= 4'(MEM_LAT);
              state    <= RD;
            end
          end
        end
        RD: begin
          // Terminal count marks the cycle in which the RAM word is valid.
          if (wait_cnt == 4'd0) begin
            if (we_q) begin
              wword_q <= merge_word;
              w_en_q  <= 1'b1;
              state   <= WR;
            end else begin
              rdata_q <= load_ext;
              valid_q <= 1'b1;
              state   <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WR: begin
          w_en_q  <= 1'b0;
          valid_q <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are masked during reset so an interrupted access leaves no trace.
  assign req_ready = (state == IDLE);
  assign rsp_valid = valid_q && !rst;
  assign mem_w_en  = w_en_q && !rst;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wword_q;

endmodule

// File: tb/tb_lsu_subword.sv
// Randomized bench for lsu_subword: two instances (MEM_LAT 1 and 3), each with its own RAM,
// checked against a byte-addressed memory model.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_clr;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [29:0] mem_addr  [2];
  logic        mem_w_en  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] ram  [2][256];
  logic [31:0] pipe [2][16];

  logic [7:0]  ref_b [2][1024];
  logic [31:0] hold  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_subword #(.ADDR_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_f3(req_f3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_addr(mem_addr[0]), .mem_w_en(mem_w_en[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  lsu_subword #(.ADDR_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_f3(req_f3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_addr(mem_addr[1]), .mem_w_en(mem_w_en[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  // RAM: read word appears MEM_LAT cycles after its address is presented.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_clr) begin
        for (int i = 0; i < 256; i++) ram[g][i] <= 32'd0;
      end else if (mem_w_en[g]) begin
        ram[g][mem_addr[g][7:0]] <= mem_wdata[g];
      end
      pipe[g][0] <= ram[g][mem_addr[g][7:0]];
      for (int i = 1; i < 16; i++) pipe[g][i] <= pipe[g][i-1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int g, input int wb);
    return {ref_b[g][wb+3], ref_b[g][wb+2], ref_b[g][wb+1], ref_b[g][wb]};
  endfunction

  // One request on instance g; rst_k>0 pulses reset in cycle T+rst_k.
  task automatic run_req(input int g, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int rst_k);
    int    lat = (g == 0) ? 1 : 3;
    int    size;
    bit    illegal, mis, err;
    int    base, wb;
    longint v;
    logic [31:0] exp_rd, exp_word;
    int    exp_lat, exp_wk;
    int    w, rk, wk, wcnt;
    bit    addr_bad;
    logic  rerr;
    logic [31:0] rdat, wdat;

    illegal = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis     = (addr % size) != 0;
`ifdef LSU_MISALIGN_ERR_EN
    err = illegal || mis;
`else
    err = illegal;
`endif
    base = int'(addr & 32'h3FF);
    base = base - (base % size);
    wb   = base & ~3;

    v = 0;
    for (int i = 0; i < size; i++) v |= longint'(ref_b[g][base+i]) << (8*i);
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1))) v -= (longint'(1) << (8*size));
    exp_rd = (err || we) ? hold[g] : v[31:0];

    if (err)            begin exp_lat = 1;       exp_wk = -1;    end
    else if (!we)       begin exp_lat = 2 + lat; exp_wk = -1;    end
    else if (size == 4) begin exp_lat = 2;       exp_wk = 1;     end
    else                begin exp_lat = 3 + lat; exp_wk = 2 + lat; end

    @(negedge clk);
    req_valid[g] = 1'b1; req_we[g] = we; req_f3[g] = f3;
    req_addr[g] = addr;  req_wdata[g] = wd;
    #1;
    w = 0;
    while (!req_ready[g] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check_val("accept_wait", w, 0);

    rk = -1; wk = -1; wcnt = 0; addr_bad = 0; rerr = 1'bx; rdat = 'x; wdat = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid[g] = 1'b0;
        req_we[g] = $urandom_range(0, 1); req_f3[g] = 3'($urandom);
        req_addr[g] = $urandom; req_wdata[g] = $urandom;
      end
      if (rst_k > 0 && k == rst_k) rst = 1'b1;
      if (rst_k > 0 && k == rst_k + 1) rst = 1'b0;
      #1;
      if (mem_w_en[g]) begin wcnt++; wk = k; wdat = mem_wdata[g]; end
      if ((rst_k == 0 || k <= rst_k) && mem_addr[g] !== addr[31:2]) addr_bad = 1;
      if (rsp_valid[g]) begin rk = k; rerr = rsp_err[g]; rdat = rsp_rdata[g]; break; end
      if (rst_k > 0 && k == rst_k + 1) begin
        check_val("rst_ready", {31'd0, req_ready[g]}, 1);
        break;
      end
    end

    if (rst_k > 0) begin
      check_val("rst_no_rsp", rk, -1);
      check_val("rst_no_wen", wcnt, 0);
      check_val("rst_maddr", {31'd0, addr_bad}, 0);
      hold[0] = 32'd0;
      hold[1] = 32'd0;
      return;
    end

    if (we && !err) begin
      for (int i = 0; i < size; i++) ref_b[g][base+i] = wd[8*i +: 8];
    end
    exp_word = ref_word(g, wb);
    if (!we && !err) hold[g] = exp_rd;

    check_val("rsp_lat", rk, exp_lat);
    check_val("rsp_err", {31'd0, rerr}, {31'd0, err});
    check_val("rsp_rdata", rdat, exp_rd);
    check_val("maddr_stable", {31'd0, addr_bad}, 0);
    check_val("wen_count", wcnt, (exp_wk < 0) ? 0 : 1);
    if (exp_wk >= 0) begin
      check_val("wen_cycle", wk, exp_wk);
      check_val("mem_wdata", wdat, exp_word);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_we[g] = 1'b0; req_f3[g] = 3'd0;
      req_addr[g] = 32'd0; req_wdata[g] = 32'd0; hold[g] = 32'd0;
      for (int i = 0; i < 1024; i++) ref_b[g][i] = 8'd0;
    end
    rst = 1'b1; ram_clr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check_val("rst_ready", {31'd0, req_ready[g]}, 1);
      check_val("rst_rsp_valid", {31'd0, rsp_valid[g]}, 0);
      check_val("rst_rsp_err", {31'd0, rsp_err[g]}, 0);
      check_val("rst_rdata", rsp_rdata[g], 0);
      check_val("rst_maddr", {2'b00, mem_addr[g]}, 0);
      check_val("rst_wen", {31'd0, mem_w_en[g]}, 0);
      check_val("rst_wdata", mem_wdata[g], 0);
    end
    rst = 1'b0; ram_clr = 1'b0;

    for (int g = 0; g < 2; g++) run_req(g, 1, 3'd2, 32'h100, 32'h88776655, 0);

    run_req(0, 0, 3'd0, 32'h103, 0, 0);
    run_req(0, 0, 3'd4, 32'h103, 0, 0);
    run_req(0, 0, 3'd5, 32'h102, 0, 0);
    run_req(0, 0, 3'd1, 32'h100, 0, 0);
    run_req(0, 1, 3'd0, 32'h101, 32'h123456AA, 0);
    run_req(0, 0, 3'd2, 32'h100, 0, 0);
    run_req(0, 1, 3'd2, 32'h200, 32'hDEADBEEF, 0);
    run_req(0, 0, 3'd2, 32'h200, 0, 0);
    run_req(0, 1, 3'd2, 32'h100, 32'h88776655, 0);
    run_req(0, 0, 3'd2, 32'h102, 0, 0);
    run_req(0, 0, 3'd3, 32'h100, 0, 0);
    run_req(0, 1, 3'd5, 32'h100, 32'h11111111, 0);
    run_req(0, 1, 3'd1, 32'h102, 32'h0000CAFE, 2);
    run_req(0, 0, 3'd2, 32'h100, 0, 0);
    run_req(0, 1, 3'd2, 32'hFFFFFFF0, 32'hA5A5C3C3, 0);
    run_req(0, 0, 3'd2, 32'h000003F0, 0, 0);
    run_req(1, 0, 3'd0, 32'h103, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int g;
      logic [31:0] a;
      g = (n % 4 == 3) ? 1 : 0;
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) a = a | 32'hFFFFFC00;
      run_req(g, bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the multicycle CPU's MEM stage and the word-wide, little-endian data RAM.
- Accepts one byte/half/word load or store per request. Sub-word stores are done as read-modify-write; load data is sign- or zero-extended.
- Raises an error on illegal funct3 or misaligned access.
- The CPU's MEM stage holds until rsp_valid.

Parameters:
- ADDR_W, 32: byte-address width.
- MEM_LAT, 1: RAM read latency in cycles, legal 1..15. Data is valid MEM_LAT cycles after the address is first presented.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  unit idle, request accepted when high.
- req_we  in  1  1 = store, 0 = load.
- req_f3  in  3  RV32 funct3 (load: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; store: 0 sb, 1 sh, 2 sw).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; for sb/sh the low bits are used.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; held until the next load response.
- rsp_err  out  1  valid with rsp_valid; illegal or misaligned access.
- mem_addr  out  ADDR_W-2  registered word address.
- mem_w_en  out  1  RAM write enable.
- mem_wdata  out  32  RAM write word.
- mem_rdata  in  32  RAM read word.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, ports named clk and rst.
  - On reset: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_addr=0; mem_w_en=0; mem_wdata=0; wait counter=0.
- Accept: accept = req_valid && req_ready, with req_ready high only in IDLE. Call the accept cycle T. At T the unit latches we, f3, addr, wdata and sets mem_addr = addr[ADDR_W-1:2].
- States: IDLE, RD, WR, RESP.
  - IDLE -> RESP on an error.
  - IDLE -> WR for sw.
  - IDLE -> RD for loads, sb and sh.
  - RD lasts MEM_LAT+1 cycles (T+1 .. T+1+MEM_LAT) with mem_addr held stable. In the last RD cycle mem_rdata is sampled:
    - load: extract and extend into rsp_rdata -> RESP.
    - sb/sh: merge the store lane into the sampled word -> mem_wdata -> WR.
  - WR: mem_w_en=1 for exactly one cycle -> RESP.
  - RESP: rsp_valid=1 for one cycle -> IDLE.
- Latency (rsp_valid cycle):
  - error: T+1.
  - sw: T+2, with the write at T+1.
  - load: T+2+MEM_LAT.
  - sb/sh: T+3+MEM_LAT, with the write at T+2+MEM_LAT.
- Lanes (little-endian):
  - byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
  - sw writes req_wdata unmodified.
  - Merge replaces only the target byte/half; other bytes are kept from the read word.
- Errors:
  - Illegal f3 (load 3/6/7; store 3..7) always sets rsp_err.
  - No RAM read or write occurs on an error.
  - rsp_rdata is unchanged on an error and on stores.
- Boundaries:
  - req_valid outside IDLE is ignored; the requester must hold it.
  - Back-to-back requests: the next accept is possible in the cycle after RESP.
  - Reset mid-operation: mem_w_en and rsp_valid are gated by !rst in the rst cycle, so no partial write or response occurs. The unit returns to IDLE at the next edge.
  - mem_addr wraps naturally at ADDR_W-2 bits.

Optional Feature:
- LSU_MISALIGN_ERR_EN defined: misaligned accesses error (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) -> rsp_err=1 at T+1.
- Undefined: no misalignment error. The low address bits below the access size are forced to zero and the access proceeds as aligned.
- Illegal-f3 errors are unaffected by the macro.

Test Plan:
- Preload: RAM word 0x40 (byte address 0x100) = 0x88776655; MEM_LAT=1 unless stated.
- Loads:
  - lb 0x103 -> rsp_rdata=0xFFFFFF88, rsp_err=0, rsp_valid at T+3.
  - lbu 0x103 -> 0x00000088.
  - lhu 0x102 -> 0x00008877.
  - lh 0x100 -> 0x00006655.
- sb 0x101, wdata 0x123456AA:
  - read at mem_addr 0x40.
  - mem_w_en exactly one cycle at T+3 with mem_wdata=0x8877AA55.
  - rsp_valid at T+4.
  - follow-up lw 0x100 -> 0x8877AA55.
- sw 0x200, wdata 0xDEADBEEF:
  - mem_addr=0x80, mem_w_en at T+1, rsp_valid at T+2.
  - next request accepted at T+3; lw 0x200 -> 0xDEADBEEF.
- Errors:
  - lw 0x102 with LSU_MISALIGN_ERR_EN -> rsp_err=1 at T+1, mem_w_en never high.
  - lw 0x102 without the macro -> rsp_rdata=0x88776655, rsp_err=0.
  - load f3=3 -> rsp_err=1 in both builds.
- Reset and latency:
  - sh 0x102 with rst high at T+2 -> no mem_w_en; rsp_valid stays 0; req_ready=1 at T+3; RAM word unchanged.
  - MEM_LAT=3, lb 0x103 -> 0xFFFFFF88 at T+5, with mem_addr stable over T+1..T+4.
